issue_ctrl: RTL

Issue/hazard controller between decode and execute of the RV64 integer pipeline. Tracks in-flight destination registers in a 32-entry scoreboard and stalls decode on RAW hazards. Sequences the squash of wrong-path instructions after a taken branch/jump, replacing execute's local one-cycle squash flop. Exports stall/flush event counters for performance debug.

---
 rtl/issue_ctrl_pkg.sv | 8 +
 rtl/issue_scoreboard.sv | 27 ++
 rtl/issue_ctrl.sv | 70 +++++++
 3 files changed

// File: rtl/issue_ctrl_pkg.sv
// issue_ctrl_pkg: register-index width, x0 constant and FSM states shared by the issue controller
package issue_ctrl_pkg;
  localparam int REG_W = 5;
  localparam int NREGS = 1 << REG_W;
  localparam logic [REG_W-1:0] X0 = '0;
  localparam int FCNT_W = 3;
  typedef enum logic {RUN, FLUSH} state_t;
endpackage

// File: rtl/issue_scoreboard.sv
// issue_scoreboard: pending-writer bit per register with write-through lookups
module issue_scoreboard
  import issue_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             set_en,
  input  logic [REG_W-1:0] set_sel,
  input  logic             clr_en,
  input  logic [REG_W-1:0] clr_sel,
  input  logic [REG_W-1:0] rs1_sel,
  input  logic [REG_W-1:0] rs2_sel,
  output logic             rs1_pend,
  output logic             rs2_pend
);
  logic [NREGS-1:0] pend, set_vec, clr_vec;
  always_comb begin
    set_vec = set_en ? (NREGS'(1) << set_sel) : '0;
    clr_vec = clr_en ? (NREGS'(1) << clr_sel) : '0;
  end
  // set applied after clear so a same-cycle issue wins; bit 0 is forced clear
  always_ff @(posedge clk)
    if (reset) pend <= '0;
    else pend <= ((pend & ~clr_vec) | set_vec) & ~NREGS'(1);
  assign rs1_pend = pend[rs1_sel] & ~clr_vec[rs1_sel];
  assign rs2_pend = pend[rs2_sel] & ~clr_vec[rs2_sel];
endmodule

// File: rtl/issue_ctrl.sv
// issue_ctrl: RAW hazard stall, redirect squash sequencing and stall/flush counters between decode and execute
module issue_ctrl
  import issue_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             decode_valid,
  output logic             decode_retry,
  input  logic [REG_W-1:0] decode_rs1_sel,
  input  logic [REG_W-1:0] decode_rs2_sel,
  input  logic             decode_rs1_used,
  input  logic             decode_rs2_used,
  input  logic [REG_W-1:0] decode_rd_sel,
  input  logic             decode_rd_write,
  output logic             execute_valid,
  input  logic             execute_retry,
  input  logic             wb_valid,
  input  logic [REG_W-1:0] wb_rd_sel,
  input  logic             branch_target_enable,
  input  logic [63:0]      branch_target,
  output logic             fetch_redirect,
  output logic [63:0]      fetch_pc,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);
  state_t state, state_nxt;
  logic [FCNT_W-1:0] cnt, cnt_nxt;
  logic run, hazard, drop, rs1_pend, rs2_pend;
  issue_scoreboard u_sb (
    .clk      (clk),
    .reset    (reset),
    .set_en   (execute_valid & decode_rd_write & (decode_rd_sel != X0)),
    .set_sel  (decode_rd_sel),
    .clr_en   (wb_valid),
    .clr_sel  (wb_rd_sel),
    .rs1_sel  (decode_rs1_sel),
    .rs2_sel  (decode_rs2_sel),
    .rs1_pend (rs1_pend),
    .rs2_pend (rs2_pend)
  );
  always_comb begin
    run = state == RUN;
    hazard = decode_valid & ((decode_rs1_used & (decode_rs1_sel != X0) & rs1_pend) |
                             (decode_rs2_used & (decode_rs2_sel != X0) & rs2_pend));
    execute_valid = decode_valid & ~hazard & ~execute_retry & ~branch_target_enable & run;
    decode_retry = decode_valid & run & ~branch_target_enable & (hazard | execute_retry);
    fetch_redirect = branch_target_enable;
    fetch_pc = branch_target_enable ? branch_target : '0;
    drop = decode_valid & (branch_target_enable | ~run);
    // a redirect seen while already flushing is ignored
    state_nxt = run ? ((branch_target_enable && FLUSH_CYCLES > 1) ? FLUSH : RUN)
                    : ((cnt == FCNT_W'(1)) ? RUN : FLUSH);
    cnt_nxt = run ? FCNT_W'(FLUSH_CYCLES - 1) : cnt - FCNT_W'(1);
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= RUN;
      cnt <= '0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      stall_count <= stall_count + CNT_W'(decode_retry & hazard);
      flush_count <= flush_count + CNT_W'(drop);
    end
endmodule
